instr_sequencer: RTL and testbench

Multi-cycle control FSM for the 16-bit processor datapath.
- Fetches each instruction over a shared single-port memory handshake.
- Decodes it and generates the extended immediate (sign, zero, or upper-byte).
- Sequences ALU, memory and register-file writeback, one instruction at a time.
- Sits between instruction/data memory, the register file and the ALU. It replaces standalone immediate-extension logic.

---
 rtl/instr_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the 16-bit datapath, including immediate extension.
// Optional retired-instruction counter on instr_count is enabled by defining SEQ_PERF_CNT_EN.
module instr_sequencer #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              addr_sel,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        rdest,
  output logic [3:0]        rsrc,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic [DATA_W-1:0] imm,
  output logic              alu_en,
  output logic              reg_we,
  output logic              wb_sel,
  output logic              pc_inc,
  output logic              illegal,
  output logic              bus_err,
  output logic [2:0]        state,
  output logic [15:0]       instr_count
);

  // state  | meaning
  // FETCH  | read instruction at PC into ir
  // DECODE | classify opcode, latch extended immediate
  // EXEC   | ALU capture; route to MEM, WB, or retire (CMPI)
  // MEM    | data access at register[rsrc]
  // WB     | register write, retire
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [7:0]        tcnt_q, tcnt_d;

  logic [3:0]        opcode;
  logic [3:0]        ext;
  logic              is_rtype, is_sign, is_zero, is_upper;
  logic              is_load, is_stor, is_cmpi, is_imm_form, is_legal;
  logic              in_access, expired;
  logic [DATA_W-1:0] ext_imm;

  assign opcode      = ir_q[15:12];
  assign ext         = ir_q[7:4];

  assign is_rtype    = (opcode == 4'h0);
  assign is_sign     = (opcode == 4'h5) || (opcode == 4'h9) || (opcode == 4'hB);
  assign is_zero     = (opcode == 4'h1) || (opcode == 4'h2) || (opcode == 4'h3) || (opcode == 4'hD);
  assign is_upper    = (opcode == 4'hF);
  assign is_load     = (opcode == 4'h4) && (ext == 4'h0);
  assign is_stor     = (opcode == 4'h4) && (ext == 4'h4);
  assign is_cmpi     = (opcode == 4'hB);
  assign is_imm_form = is_sign || is_zero || is_upper;
  assign is_legal    = is_rtype || is_imm_form || is_load || is_stor;

  always_comb begin
    ext_imm = '0;
    if (is_sign) begin
      ext_imm = {{8{ir_q[7]}}, ir_q[7:0]};
    end else if (is_zero) begin
      ext_imm = {8'h00, ir_q[7:0]};
    end else if (is_upper) begin
      ext_imm = {ir_q[7:0], 8'h00};
    end
  end

  // The expiry cycle itself no longer requests; a late mem_ready there still completes.
  assign in_access = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign expired   = in_access && (tcnt_q == TO_LIM);

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    imm_d       = imm_q;
    tcnt_d      = tcnt_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    alu_src_imm = 1'b0;
    alu_en      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    pc_inc      = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;

    if (reset) begin
      state_d = ST_FETCH;
      ir_d    = '0;
      imm_d   = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          mem_req = !expired;
          if (mem_ready) begin
            ir_d    = mem_rdata;
            state_d = ST_DECODE;
          end else if (expired) begin
            bus_err = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (is_legal) begin
            imm_d   = ext_imm;
            state_d = ST_EXEC;
          end else begin
            imm_d   = '0;
            illegal = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_EXEC: begin
          alu_en      = 1'b1;
          alu_src_imm = is_imm_form;
          if (is_load || is_stor) begin
            state_d = ST_MEM;
          end else if (is_cmpi) begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req  = !expired;
          mem_we   = is_stor && !expired;
          addr_sel = 1'b1;
          if (mem_ready) begin
            if (is_stor) begin
              pc_inc  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (expired) begin
            bus_err = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_WB: begin
          reg_we  = 1'b1;
          wb_sel  = is_load;
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase

      // FETCH->FETCH on expiry is not a state change, so expiry clears explicitly.
      if ((state_d != state_q) || mem_ready || expired) begin
        tcnt_d = '0;
      end else if (mem_req) begin
        tcnt_d = tcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ir_q    <= ir_d;
    imm_q   <= imm_d;
    tcnt_q  <= tcnt_d;
  end

  assign state  = state_q;
  assign ir     = ir_q;
  assign imm    = imm_q;
  assign rdest  = ir_q[11:8];
  assign rsrc   = ir_q[3:0];
  assign alu_op = is_rtype ? ir_q[7:4] : opcode;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = '0;
    end else if (pc_inc) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a transaction-level model expands each instruction into expected per-cycle rows,
// which are replayed against the DUT and compared on every cycle.
module tb_instr_sequencer;

  localparam int TO = 15;

  localparam int K_RT   = 0;
  localparam int K_SIGN = 1;
  localparam int K_ZERO = 2;
  localparam int K_UP   = 3;
  localparam int K_LD   = 4;
  localparam int K_ST   = 5;
  localparam int K_ILL  = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, alu_src_imm, alu_en, reg_we, wb_sel, pc_inc, illegal, bus_err;
  logic [15:0] ir, imm, instr_count;
  logic [3:0]  rdest, rsrc, alu_op;
  logic [2:0]  state;

  always #5 clk = ~clk;

  instr_sequencer #(.DATA_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir(ir),
    .rdest(rdest), .rsrc(rsrc), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .imm(imm), .alu_en(alu_en), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_inc(pc_inc), .illegal(illegal), .bus_err(bus_err), .state(state),
    .instr_count(instr_count)
  );

  // One row per clock cycle: stimulus plus the outputs that cycle must show.
  typedef struct {
    bit          rst;
    bit          rdy;
    logic [15:0] rdata;
    bit          xs;
    bit          req, we, asel, aen, simm, rwe, wsel, pinc, ill, berr;
    logic [2:0]  st;
    logic [15:0] ir_v, imm_v, cnt_v;
  } row_t;

  row_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          row_idx = 0;
  logic [15:0] m_ir = '0, m_imm = '0, m_cnt = '0;
  logic [15:0] exec_imm[$];
  int          n_rwe = 0, n_berr = 0, n_ill = 0, first_pinc = -1;
  logic [3:0]  legal_ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};

  function automatic int kind(input logic [15:0] i);
    case (i[15:12])
      4'h0:                      return K_RT;
      4'h1, 4'h2, 4'h3, 4'hD:    return K_ZERO;
      4'h5, 4'h9, 4'hB:          return K_SIGN;
      4'hF:                      return K_UP;
      4'h4: begin
        if (i[7:4] == 4'h0) return K_LD;
        if (i[7:4] == 4'h4) return K_ST;
        return K_ILL;
      end
      default:                   return K_ILL;
    endcase
  endfunction

  function automatic logic [15:0] ext_of(input logic [15:0] i);
    int k;
    k = kind(i);
    if (k == K_SIGN) return {{8{i[7]}}, i[7:0]};
    if (k == K_ZERO) return {8'h00, i[7:0]};
    if (k == K_UP)   return {i[7:0], 8'h00};
    return 16'h0000;
  endfunction

  function automatic logic [3:0] exp_aluop(input logic [15:0] i);
    return (i[15:12] == 4'h0) ? i[7:4] : i[15:12];
  endfunction

  function automatic row_t blank(input logic [2:0] st);
    row_t r;
    r.rst = 1'b0; r.rdy = 1'($urandom % 2); r.rdata = 16'($urandom); r.xs = 1'b0;
    r.req = 0; r.we = 0; r.asel = 0; r.aen = 0; r.simm = 0;
    r.rwe = 0; r.wsel = 0; r.pinc = 0; r.ill = 0; r.berr = 0;
    r.st = st; r.ir_v = m_ir; r.imm_v = m_imm; r.cnt_v = m_cnt;
    return r;
  endfunction

  function automatic void bump();
`ifdef SEQ_PERF_CNT_EN
    m_cnt = m_cnt + 16'd1;
`endif
  endfunction

  // wt idle-ready cycles before mem_ready; wt == TO completes in the expiry cycle, wt > TO times out.
  task automatic gen_access(input logic [2:0] st, input bit stor, input int wt,
                            input logic [15:0] data, output bit ok);
    row_t r;
    int   nw;
    nw = (wt < TO) ? wt : TO;
    for (int i = 0; i < nw; i++) begin
      r = blank(st); r.rdy = 1'b0; r.req = 1'b1; r.we = stor; r.asel = (st == 3'd3);
      q.push_back(r);
    end
    r = blank(st);
    r.asel = (st == 3'd3);
    if (wt < TO) begin
      r.rdy = 1'b1; r.rdata = data; r.req = 1'b1; r.we = stor; ok = 1'b1;
    end else if (wt == TO) begin
      r.rdy = 1'b1; r.rdata = data; ok = 1'b1;
    end else begin
      r.rdy = 1'b0; r.berr = 1'b1; ok = 1'b0;
    end
    if (ok && stor) r.pinc = 1'b1;
    q.push_back(r);
    if (ok && stor) bump();
    if (ok && st == 3'd0) m_ir = data;
  endtask

  task automatic gen_reset(input logic [2:0] st);
    row_t r;
    r = blank(st); r.rst = 1'b1; r.xs = 1'b1;
    q.push_back(r);
    m_ir = '0; m_imm = '0; m_cnt = '0;
    r = blank(3'd0); r.rst = 1'b1;
    q.push_back(r);
  endtask

  task automatic gen_instr(input logic [15:0] instr, input int fw, input int mw, input int rst_wait);
    bit   ok, fin;
    row_t r;
    int   k;
    fin = 1'b0;
    while (!fin) begin
      gen_access(3'd0, 1'b0, fw, instr, ok);
      fw = $urandom_range(0, 3);
      if (ok) begin
        k = kind(m_ir);
        r = blank(3'd1);
        if (k == K_ILL) begin
          r.ill = 1'b1; r.pinc = 1'b1; q.push_back(r);
          m_imm = '0; bump(); fin = 1'b1;
        end else begin
          q.push_back(r);
          m_imm = ext_of(m_ir);
          r = blank(3'd2); r.aen = 1'b1; r.simm = (k == K_SIGN || k == K_ZERO || k == K_UP);
          if (m_ir[15:12] == 4'hB) begin
            r.pinc = 1'b1; q.push_back(r); bump(); fin = 1'b1;
          end else begin
            q.push_back(r);
            if (k == K_LD || k == K_ST) begin
              if (rst_wait >= 0) begin
                for (int i = 0; i < rst_wait; i++) begin
                  r = blank(3'd3); r.rdy = 1'b0; r.req = 1'b1; r.asel = 1'b1; r.we = (k == K_ST);
                  q.push_back(r);
                end
                gen_reset(3'd3);
                fin = 1'b1;
              end else begin
                gen_access(3'd3, k == K_ST, mw, 16'($urandom), ok);
                mw = $urandom_range(0, 3);
                if (ok && k == K_ST) begin
                  fin = 1'b1;
                end else if (ok) begin
                  r = blank(3'd4); r.rwe = 1'b1; r.wsel = 1'b1; r.pinc = 1'b1;
                  q.push_back(r); bump(); fin = 1'b1;
                end
              end
            end else begin
              r = blank(3'd4); r.rwe = 1'b1; r.pinc = 1'b1;
              q.push_back(r); bump(); fin = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row_idx, act, exp);
    end
  endtask

  task automatic pin(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    check(nm, act, exp);
  endtask

  task automatic run_q();
    row_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      #1;
      reset = r.rst; mem_ready = r.rdy; mem_rdata = r.rdata;
      @(negedge clk);
      vectors++;
      if (!r.xs) begin
        check("mem_req", 16'(mem_req), 16'(r.req));
        check("mem_we", 16'(mem_we), 16'(r.we));
        check("addr_sel", 16'(addr_sel), 16'(r.asel));
        check("alu_en", 16'(alu_en), 16'(r.aen));
        check("alu_src_imm", 16'(alu_src_imm), 16'(r.simm));
        check("reg_we", 16'(reg_we), 16'(r.rwe));
        check("wb_sel", 16'(wb_sel), 16'(r.wsel));
        check("pc_inc", 16'(pc_inc), 16'(r.pinc));
        check("illegal", 16'(illegal), 16'(r.ill));
        check("bus_err", 16'(bus_err), 16'(r.berr));
      end
      check("state", 16'(state), 16'(r.st));
      check("ir", ir, r.ir_v);
      check("imm", imm, r.imm_v);
      check("instr_count", instr_count, r.cnt_v);
      check("alu_op", 16'(alu_op), 16'(exp_aluop(r.ir_v)));
      check("rdest", 16'(rdest), 16'(r.ir_v[11:8]));
      check("rsrc", 16'(rsrc), 16'(r.ir_v[3:0]));
      if (state == 3'd2) exec_imm.push_back(imm);
      if (reg_we === 1'b1) n_rwe++;
      if (bus_err === 1'b1) n_berr++;
      if (illegal === 1'b1) n_ill++;
      if (pc_inc === 1'b1 && first_pinc < 0) first_pinc = row_idx;
      row_idx++;
      @(posedge clk);
    end
  endtask

  function automatic logic [15:0] exec_at(input int i);
    if (i < exec_imm.size()) return exec_imm[i];
    return 16'hxxxx;
  endfunction

  function automatic int pick_wait();
    int s;
    s = $urandom % 20;
    if (s < 14) return $urandom_range(0, 3);
    if (s == 14) return TO - 1;
    if (s == 15) return TO;
    if (s == 16) return TO + 2;
    return 0;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);

    gen_instr(16'h51F6, 1, 0, -1);  run_q();
    gen_instr(16'hF2AB, 0, 0, -1);  run_q();
    gen_instr(16'h22CD, 2, 0, -1);  run_q();
    gen_instr(16'h4302, 0, 3, -1);  run_q();
    gen_instr(16'h4745, 0, 0, -1);  run_q();
    gen_instr(16'h5A01, 99, 0, -1); run_q();
    gen_instr(16'h5B02, TO, 0, -1); run_q();
    gen_instr(16'h1C03, TO - 1, 0, -1); run_q();
    gen_instr(16'h4A0C, 0, 99, -1); run_q();
    gen_instr(16'h7000, 0, 0, -1);  run_q();
    gen_instr(16'hB5FF, 1, 0, -1);  run_q();
    gen_instr(16'h4302, 0, 0, 2);   run_q();
    gen_instr(16'h5301, 0, 0, -1);  run_q();

    pin("addi_imm", exec_at(0), 16'hFFF6);
    pin("lui_imm", exec_at(1), 16'hAB00);
    pin("ori_imm", exec_at(2), 16'h00CD);
    pin("load_imm", exec_at(3), 16'h0000);
    pin("addi_cycles", 16'(first_pinc + 1), 16'd5);
    pin("reg_we_pulses", 16'(n_rwe), 16'd9);
    pin("bus_err_pulses", 16'(n_berr), 16'd2);
    pin("illegal_pulses", 16'(n_ill), 16'd1);

    for (int n = 0; n < 250; n++) begin
      logic [15:0] ins;
      int          fw, mw, rw;
      ins = 16'($urandom);
      if ($urandom % 8 != 0) ins[15:12] = legal_ops[$urandom % 10];
      if (ins[15:12] == 4'h4 && ($urandom % 6 != 0)) ins[7:4] = ($urandom % 2 != 0) ? 4'h4 : 4'h0;
      fw = pick_wait();
      mw = pick_wait();
      rw = ($urandom % 25 == 0) ? int'($urandom_range(0, 5)) : -1;
      gen_instr(ins, fw, mw, rw);
      run_q();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
